prog_loader: RTL
================

Name: prog_loader

Overview:
- Hardware writer for the rv32i instruction memory. Replaces the simulation-only file preload with a byte-stream boot path.
- Receives a framed byte stream and assembles little-endian 32-bit instruction words. Writes each word into instruction memory through a single-cycle write port.
- Holds the CPU stalled or in reset until the whole image is loaded and the checksum verifies.
- Sits between a byte source (UART receiver or bench) and the instruction-memory write port.

Parameters:
ADDR_W, 8, instruction-memory word-address width; DEPTH = 2**ADDR_W words.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-high reset.
byte_valid  input  1  source has a byte on byte_data.
byte_data  input  8  stream byte.
byte_ready  output  1  loader can accept a byte; a transfer occurs on a clk edge when byte_valid && byte_ready.
imem_we  output  1  instruction-memory write strobe, one cycle per word.
imem_addr  output  ADDR_W  word address, not byte address.
imem_wdata  output  32  instruction word.
cpu_hold  output  1  high while the CPU must not run.
done  output  1  image loaded and checksum OK.
err  output  2  00 none, 01 length overflow, 10 checksum mismatch.
words_loaded  output  ADDR_W+1  count of words written so far.

Behaviour:
- Reset is asynchronous and active-high. Every output is registered.
- Reset values:
  - byte_ready=1, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_hold=1, done=0, err=00, words_loaded=0.
  - State = S_LEN; byte counter, length register and running XOR all cleared.
- Frame format:
  - 4 length bytes: N, little-endian 32-bit word count.
  - N×4 data bytes: each word little-endian, first byte → bits[7:0].
  - 1 checksum byte: XOR of every preceding frame byte, length bytes included.
- The running XOR updates on every accepted byte except the checksum byte.
- S_LEN:
  - Shift accepted bytes into the length register.
  - On the 4th byte: N=0 → S_CSUM; N>DEPTH → S_ERR with err=01; otherwise → S_DATA.
- S_DATA:
  - Assemble 4 bytes per word.
  - The cycle after the 4th byte is accepted: imem_we=1 for exactly one cycle, imem_addr=word index (0..N-1), imem_wdata=assembled word. words_loaded increments in the same cycle.
  - After word N-1 is accepted, move to S_CSUM.
  - byte_ready stays high; there is no write backpressure, and back-to-back bytes every cycle must be supported.
- S_CSUM:
  - Accept 1 byte.
  - Equal to running XOR → S_DONE. Otherwise → S_ERR with err=10.
- Transition side effects:
  - In the cycle after entering S_DONE or S_ERR, byte_ready=0.
  - Entering S_DONE sets done=1 and cpu_hold=0, both in that same cycle.
- Terminal states:
  - S_DONE and S_ERR hold until rst.
  - In S_ERR, cpu_hold stays 1 and err is held.
  - Bytes offered in either state are not accepted.
- Boundary conditions:
  - N=DEPTH is legal; the last write goes to address DEPTH-1.
  - imem_addr never wraps.
  - byte_valid low mid-word stalls with no timeout; partial word state is kept.
- Reset mid-load:
  - Returns to S_LEN immediately and clears counters, XOR and flags.
  - Memory contents already written are not erased.
  - An imem_we pulse in flight is deasserted asynchronously.
- imem_we and the final-word write may coincide with acceptance of the checksum byte. The ordering is fixed: the write occurs, then done asserts the cycle after the checksum byte.

Test Plan:
- Nominal 2-word image:
  - Stimulus: bytes 02 00 00 00, 93 00 10 00, 93 80 10 00, 82, one per cycle.
  - Required: writes 0x00100093@0 and 0x00108093@1, one imem_we pulse each; words_loaded=2; done=1, cpu_hold=0, err=00; byte_ready=0 afterwards.
- Bad checksum:
  - Stimulus: same stream with final byte 83.
  - Required: both writes occur, err=10, done=0, cpu_hold=1, byte_ready=0.
- Length overflow:
  - Stimulus: bytes 01 01 00 00 (N=257 > 256).
  - Required: err=01 the cycle after the 4th byte, no imem_we ever, byte_ready=0.
- Zero length:
  - Stimulus: bytes 00 00 00 00 00.
  - Required: no writes, done=1, cpu_hold=0.
- Gapped valid:
  - Stimulus: nominal stream with byte_valid low 3 cycles between every byte.
  - Required: identical writes and final state to the nominal case; imem_we still one cycle per word.
- Reset mid-load:
  - Stimulus: assert rst after 6 bytes of the nominal stream, then replay the full stream.
  - Required: all outputs return to reset values asynchronously; the replay completes with done=1 and correct writes at addresses 0 and 1.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream boot loader for the rv32i instruction memory: parses a length-prefixed,
// XOR-checksummed frame, writes little-endian words and releases the CPU on success.
module prog_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic [1:0]        err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned Depth  = 2 ** ADDR_W;
    localparam logic [31:0] DepthW = 32'(Depth);

    localparam logic [1:0] ErrNone  = 2'b00;
    localparam logic [1:0] ErrLen   = 2'b01;
    localparam logic [1:0] ErrCsum  = 2'b10;

    typedef enum logic [2:0] {
        StLen,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       len_q, len_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [23:0]       word_q, word_d;
    logic [7:0]        xor_q, xor_d;
    logic              byte_ready_q, byte_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [ADDR_W:0]   words_loaded_q, words_loaded_d;

    logic              accept;
    logic [31:0]       len_full;
    logic [31:0]       word_full;
    logic [ADDR_W:0]   words_next;

    assign accept     = byte_valid && byte_ready_q;
    // Length and data bytes both arrive LSB first, so shift in from the top.
    assign len_full   = {byte_data, len_q[31:8]};
    assign word_full  = {byte_data, word_q};
    assign words_next = words_loaded_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        word_d         = word_q;
        xor_d          = xor_q;
        byte_ready_d   = byte_ready_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        cpu_hold_d     = cpu_hold_q;
        done_d         = done_q;
        err_d          = err_q;
        words_loaded_d = words_loaded_q;

        case (state_q)
            StLen: begin
                if (accept) begin
                    xor_d = xor_q ^ byte_data;
                    len_d = len_full;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (len_full == 32'd0) begin
                            state_d = StCsum;
                        end else if (len_full > DepthW) begin
                            state_d      = StErr;
                            err_d        = ErrLen;
                            byte_ready_d = 1'b0;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end

            StData: begin
                if (accept) begin
                    xor_d  = xor_q ^ byte_data;
                    cnt_d  = cnt_q + 2'd1;
                    word_d = word_full[31:8];
                    if (cnt_q == 2'd3) begin
                        imem_we_d      = 1'b1;
                        imem_addr_d    = words_loaded_q[ADDR_W-1:0];
                        imem_wdata_d   = word_full;
                        words_loaded_d = words_next;
                        // len_q <= Depth here, so its low ADDR_W+1 bits hold the full count.
                        if (words_next == len_q[ADDR_W:0]) begin
                            state_d = StCsum;
                        end
                    end
                end
            end

            StCsum: begin
                if (accept) begin
                    byte_ready_d = 1'b0;
                    if (byte_data == xor_q) begin
                        state_d    = StDone;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = StErr;
                        err_d   = ErrCsum;
                    end
                end
            end

            StDone: begin
                byte_ready_d = 1'b0;
            end

            StErr: begin
                byte_ready_d = 1'b0;
            end

            default: begin
                state_d = StLen;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StLen;
            len_q          <= '0;
            cnt_q          <= '0;
            word_q         <= '0;
            xor_q          <= '0;
            byte_ready_q   <= 1'b1;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            cpu_hold_q     <= 1'b1;
            done_q         <= 1'b0;
            err_q          <= ErrNone;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            cnt_q          <= cnt_d;
            word_q         <= word_d;
            xor_q          <= xor_d;
            byte_ready_q   <= byte_ready_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            cpu_hold_q     <= cpu_hold_d;
            done_q         <= done_d;
            err_q          <= err_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign byte_ready   = byte_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_loaded_q;

endmodule
